// File: rtl/i2c_target_rx_if.sv
// rtl/i2c_target_rx_if.sv - I2C target receiver bus and byte-stream bundle
interface i2c_target_rx_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic       o_scl_oe;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;

  modport slave (
    input  i_scl, i_sda, i_ready,
    output o_sda_oe, o_scl_oe, o_data, o_valid, o_busy
  );

  modport master (
    output i_scl, i_sda, i_ready,
    input  o_sda_oe, o_scl_oe, o_data, o_valid, o_busy
  );
endinterface

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - write-only I2C target receiver with address match and ACK
// Define I2C_TARGET_STRETCH_EN for valid/ready backpressure via SCL clock stretching.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input logic            i_clk,
  input logic            i_rst_n,
  i2c_target_rx_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q, scl_s, sda_s;
  logic                   scl_rise, scl_fall, bus_start, bus_stop;
  logic [3:0]             bitcnt_q;
  logic [7:0]             shreg_q, data_q;
  logic                   byte_done_q, valid_q;
  logic                   sda_oe_q, sda_oe_d, busy_q, busy_d, clr_cnt;
  logic                   stretch_q;

  // Bus idles high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.i_sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign bus_start = scl_s & scl_q & sda_q & ~sda_s;
  assign bus_stop  = scl_s & scl_q & ~sda_q & sda_s;
  assign scl_rise  = scl_s & ~scl_q & ~bus_start & ~bus_stop;
  assign scl_fall  = ~scl_s & scl_q & ~bus_start & ~bus_stop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    clr_cnt  = 1'b0;
    if (bus_start) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      clr_cnt  = 1'b1;
    end else if (bus_stop) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: begin
          if (bitcnt_q == 4'd8) begin
            if (shreg_q[7:1] == ADDR && !shreg_q[0]) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = S_ADDR_ACK;
            end else begin
              state_d  = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          sda_oe_d = 1'b0;
          clr_cnt  = 1'b1;
          state_d  = S_DATA;
        end
        S_DATA: begin
          if (bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = S_DATA_ACK;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte completion is flagged on the 8th rise and published one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q     <= 8'h00;
      bitcnt_q    <= 4'd0;
      byte_done_q <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      if (clr_cnt) begin
        bitcnt_q <= 4'd0;
      end else if (scl_rise && !stretch_q && state_q != S_IDLE && state_q != S_IGNORE) begin
        shreg_q     <= {shreg_q[6:0], sda_s};
        bitcnt_q    <= bitcnt_q + 4'd1;
        byte_done_q <= (state_q == S_DATA) && (bitcnt_q == 4'd7);
      end
      if (byte_done_q) begin
        data_q <= shreg_q;
      end
`ifdef I2C_TARGET_STRETCH_EN
      if (byte_done_q) begin
        valid_q <= 1'b1;
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
`else
      valid_q <= byte_done_q;
`endif
    end
  end

`ifdef I2C_TARGET_STRETCH_EN
  // Hold SCL low after the data ACK while the consumer still owns the last byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stretch_q <= 1'b0;
    end else if (bus_start || bus_stop || (valid_q && bus.i_ready)) begin
      stretch_q <= 1'b0;
    end else if (scl_fall && state_q == S_DATA_ACK && valid_q) begin
      stretch_q <= 1'b1;
    end
  end
  assign bus.o_scl_oe = stretch_q;
`else
  assign stretch_q    = 1'b0;
  assign bus.o_scl_oe = 1'b0;
`endif

  assign bus.o_sda_oe = sda_oe_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - directed bench for i2c_target_rx driving a wired-AND I2C bus
module tb_i2c_target_rx;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  i2c_target_rx_if bus ();

  i2c_target_rx #(.ADDR(7'h48), .SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.i_scl = m_scl & ~bus.o_scl_oe;
  assign bus.i_sda = m_sda & ~bus.o_sda_oe;

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid, run, max_run, valid_rise_cyc, last_rise, bit0_rise;
  logic       prev_valid = 1'b0, prev_oe = 1'b0;
  logic       oe_seen, scl_oe_seen, busy_seen, oe_bad;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (bus.o_valid) begin
      run++;
      if (!prev_valid) begin
        n_valid++;
        got.push_back(bus.o_data);
        valid_rise_cyc = cyc;
      end
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    prev_valid = bus.o_valid;
    if (bus.o_sda_oe) oe_seen = 1'b1;
    if (bus.o_scl_oe) scl_oe_seen = 1'b1;
    if (bus.o_busy) busy_seen = 1'b1;
    if (bus.o_sda_oe !== prev_oe && bus.i_scl === 1'b1) oe_bad = 1'b1;
    prev_oe = bus.o_sda_oe;
  end

  task automatic clr_mon();
    n_valid = 0; run = 0; max_run = 0;
    oe_seen = 1'b0; scl_oe_seen = 1'b0; busy_seen = 1'b0; oe_bad = 1'b0;
    got.delete();
  endtask

  task automatic wait_scl_high();
    int n = 0;
    #1;
    while (bus.i_scl !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL scl_release_timeout: scl=%b after %0d cycles, required 1", bus.i_scl, n);
    end
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    repeat (Q) @(negedge clk);
    m_scl = 1'b1;
    last_rise = cyc;
    wait_scl_high();
    repeat (2*Q) @(negedge clk);
    m_scl = 1'b0;
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i == 0) bit0_rise = last_rise;
    end
    m_sda = 1'b1;
    repeat (Q) @(negedge clk);
    m_scl = 1'b1;
    wait_scl_high();
    ack = 1'b1;
    repeat (2*Q) begin
      @(negedge clk);
      if (bus.i_sda !== 1'b0) ack = 1'b0;
    end
    m_scl = 1'b0;
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    repeat (Q) @(negedge clk);
    m_scl = 1'b1;
    wait_scl_high();
    repeat (Q) @(negedge clk);
    m_sda = 1'b0;
    repeat (Q) @(negedge clk);
    m_scl = 1'b0;
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    repeat (Q) @(negedge clk);
    m_scl = 1'b1;
    wait_scl_high();
    repeat (Q) @(negedge clk);
    m_sda = 1'b1;
    repeat (2*Q) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.o_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", bus.o_sda_oe); end
    checks++; if (bus.o_scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe: got %b want 0", bus.o_scl_oe); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
  endtask

  task automatic test_write();
    logic ack;
    clr_mon();
    bus_start();
    send_byte(8'h90, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %b want 1", ack); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", bus.o_busy); end
    send_byte(8'h96, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_data_ack: got %b want 1", ack); end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL write_nvalid: got %0d want 1", n_valid); end
    checks++; if (got.size() < 1 || got[0] !== 8'h96) begin errors++; $display("FAIL write_data: got %h want 96", bus.o_data); end
    checks++; if (valid_rise_cyc - bit0_rise !== 4) begin errors++; $display("FAIL write_valid_latency: got %0d want 4", valid_rise_cyc - bit0_rise); end
    checks++; if (max_run !== 1) begin errors++; $display("FAIL write_valid_width: got %0d want 1", max_run); end
    bus_stop();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_data !== 8'h96) begin errors++; $display("FAIL write_data_hold: got %h want 96", bus.o_data); end
    checks++; if (oe_bad !== 1'b0) begin errors++; $display("FAIL write_oe_scl_high: got %b want 0", oe_bad); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    clr_mon();
    bus_start();
    send_byte(8'h92, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack: got %b want 0", ack); end
    send_byte(8'hFF, ack);
    checks++; if (int'(dut.state_q) !== 5) begin errors++; $display("FAIL wrong_addr_state: got %0d want 5", int'(dut.state_q)); end
    bus_stop();
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL wrong_addr_nvalid: got %0d want 0", n_valid); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_sda_oe: got %b want 0", oe_seen); end
    checks++; if (int'(dut.state_q) !== 0) begin errors++; $display("FAIL wrong_addr_idle: got %0d want 0", int'(dut.state_q)); end
  endtask

  task automatic test_read_addr();
    logic ack;
    clr_mon();
    bus_start();
    send_byte(8'h91, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    send_byte(8'h55, ack);
    bus_stop();
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL read_nvalid: got %0d want 0", n_valid); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL read_busy: got %b want 0", busy_seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    logic ack;
    exp[0] = 8'h01; exp[1] = 8'hA5; exp[2] = 8'h3C;
    clr_mon();
    bus_start();
    send_byte(8'h90, ack);
    for (int i = 0; i < 3; i++) begin
      send_byte(exp[i], ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b want 1", i, ack); end
    end
    checks++; if (n_valid !== 3) begin errors++; $display("FAIL b2b_nvalid: got %0d want 3", n_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp[i]) begin
        errors++; $display("FAIL b2b_data%0d: got %h want %h", i, (got.size() > i) ? got[i] : 8'hxx, exp[i]);
      end
    end
    bus_start();
    send_byte(8'h90, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_restart_ack: got %b want 1", ack); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", bus.o_busy); end
    bus_stop();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h5A;
    logic ack;
    clr_mon();
    bus_start();
    send_byte(8'h90, ack);
    for (int i = 7; i >= 5; i--) send_bit(b[i]);
    m_sda = b[4];
    repeat (Q) @(negedge clk);
    m_scl = 1'b1;
    repeat (Q) @(negedge clk);
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", bus.o_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", bus.o_data); end
    checks++; if (bus.o_sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_sda_oe: got %b want 0", bus.o_sda_oe); end
    checks++; if (bus.o_valid !== 1'b0 || bus.o_scl_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_valid_scl: got %b%b want 00", bus.o_valid, bus.o_scl_oe); end
    repeat (Q) @(negedge clk);
    m_scl = 1'b0;
    repeat (Q) @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    for (int i = 3; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL rst_mid_nvalid: got %0d want 0", n_valid); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ack: got %b want 0", oe_seen); end
    bus_stop();
    clr_mon();
    bus_start();
    send_byte(8'h90, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_after_addr_ack: got %b want 1", ack); end
    send_byte(8'h42, ack);
    bus_stop();
    checks++; if (n_valid !== 1 || got.size() < 1 || got[0] !== 8'h42) begin errors++; $display("FAIL rst_after_data: got n=%0d data=%h want n=1 data=42", n_valid, bus.o_data); end
  endtask

`ifdef I2C_TARGET_STRETCH_EN
  task automatic test_stretch();
    logic ack;
    logic hold_bad = 1'b0;
    clr_mon();
    bus.i_ready = 1'b0;
    bus_start();
    send_byte(8'h90, ack);
    send_byte(8'h96, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL stretch_ack: got %b want 1", ack); end
    repeat (500) begin
      @(negedge clk);
      if (bus.o_scl_oe !== 1'b1 || bus.o_valid !== 1'b1) hold_bad = 1'b1;
    end
    checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL stretch_hold: got %b want 0", hold_bad); end
    checks++; if (bus.o_data !== 8'h96) begin errors++; $display("FAIL stretch_data: got %h want 96", bus.o_data); end
    bus.i_ready = 1'b1;
    #1;
    checks++; if (bus.o_scl_oe !== 1'b1) begin errors++; $display("FAIL stretch_hs_cycle: got %b want 1", bus.o_scl_oe); end
    @(negedge clk);
    checks++; if (bus.o_scl_oe !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL stretch_release: got scl_oe=%b valid=%b want 0 0", bus.o_scl_oe, bus.o_valid); end
    send_byte(8'h3C, ack);
    bus_stop();
    checks++; if (ack !== 1'b1 || n_valid !== 2 || got.size() < 2 || got[1] !== 8'h3C) begin errors++; $display("FAIL stretch_next: got ack=%b n=%0d data=%h want 1 2 3c", ack, n_valid, bus.o_data); end
  endtask
`else
  task automatic test_ignore_ready();
    logic ack;
    clr_mon();
    bus.i_ready = 1'b0;
    bus_start();
    send_byte(8'h90, ack);
    send_byte(8'h96, ack);
    send_byte(8'h5A, ack);
    bus_stop();
    bus.i_ready = 1'b1;
    checks++; if (n_valid !== 2 || got.size() < 2 || got[1] !== 8'h5A) begin errors++; $display("FAIL noready_bytes: got n=%0d data=%h want 2 5a", n_valid, bus.o_data); end
    checks++; if (max_run !== 1) begin errors++; $display("FAIL noready_width: got %0d want 1", max_run); end
    checks++; if (scl_oe_seen !== 1'b0) begin errors++; $display("FAIL noready_scl_oe: got %b want 0", scl_oe_seen); end
  endtask
`endif

  initial begin
    bus.i_ready = 1'b1;
    clr_mon();
    test_reset();
    test_write();
    test_wrong_addr();
    test_read_addr();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_TARGET_STRETCH_EN
    test_stretch();
`else
    test_ignore_ready();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1);
  end
endmodule
